// File: rtl/uart_tx_fifo.sv
// Wishbone UART transmitter (8N1) fed by a 2^DEPTH_LOG2-byte FIFO, with a drain interrupt.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd when CTRL[2]=1).
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int PSIZE      = 16,
  parameter int DIV_RST    = 346
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        irq,
  output logic        txd
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic                  r_ack;
  logic [31:0]           r_rdata;
  logic [PSIZE-1:0]      r_div;
  logic [PSIZE-1:0]      r_cnt;
  logic                  r_txEn;
  logic                  r_irqEn;
  logic                  r_odd;
  logic                  r_ovf;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2:0]   r_count;
  state_t                r_state;
  state_t                w_nextState;
  logic [7:0]            r_shift;
  logic [2:0]            r_bitIdx;
  logic                  r_parity;

  logic        w_req, w_wr, w_rd, w_pushReq, w_pushOk, w_ovfSet, w_ovfClr;
  logic        w_full, w_empty, w_busy, w_pop, w_bitEnd;
  logic [1:0]  w_adr;
  logic [31:0] w_status, w_rdMux;
  logic        w_unused;

  assign w_adr     = wbs_adr_i[3:2];
  assign w_req     = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_wr      = w_req & wbs_we_i;
  assign w_rd      = w_req & ~wbs_we_i;
  assign w_full    = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_busy    = (r_state != S_IDLE);
  assign w_bitEnd  = (r_cnt == '0);
  assign w_pushReq = w_wr & (w_adr == 2'd0) & wbs_sel_i[0];
  // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
  assign w_pushOk  = w_pushReq & (~w_full | w_pop);
  assign w_ovfSet  = w_pushReq & w_full & ~w_pop;
  assign w_ovfClr  = w_wr & (w_adr == 2'd1) & wbs_sel_i[0] & wbs_dat_i[3];
  assign w_unused  = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_req;
      r_rdata <= w_rd ? w_rdMux : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= PSIZE'(DIV_RST);
      r_txEn  <= 1'b0;
      r_irqEn <= 1'b0;
      r_odd   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr && w_adr == 2'd2) begin
        for (int i = 0; i < PSIZE; i++) begin
          if (wbs_sel_i[i/8]) r_div[i] <= wbs_dat_i[i];
        end
      end
      if (w_wr && w_adr == 2'd3 && wbs_sel_i[0]) begin
        r_txEn  <= wbs_dat_i[0];
        r_irqEn <= wbs_dat_i[1];
`ifdef UART_TX_PARITY_EN
        r_odd   <= wbs_dat_i[2];
`endif
      end
      if (w_ovfSet) r_ovf <= 1'b1;
      else if (w_ovfClr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_pushOk) r_mem[r_wrPtr] <= wbs_dat_i[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + DEPTH_LOG2'(1);
      if (w_pop)    r_rdPtr <= r_rdPtr + DEPTH_LOG2'(1);
      case ({w_pushOk, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_status = '0;
    w_status[0] = w_busy;
    w_status[1] = w_full;
    w_status[2] = w_empty;
    w_status[3] = r_ovf;
    w_status[8 +: DEPTH_LOG2+1] = r_count;
    w_rdMux = '0;
    case (w_adr)
      2'd1: w_rdMux = w_status;
      2'd2: w_rdMux[PSIZE-1:0] = r_div;
      2'd3: w_rdMux[2:0] = {r_odd, r_irqEn, r_txEn};
      default: w_rdMux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // tx_en only gates leaving IDLE, so a frame in flight always completes.
  always_comb begin
    w_nextState = r_state;
    w_pop = 1'b0;
    case (r_state)
      S_IDLE: if (r_txEn && !w_empty) begin
        w_pop = 1'b1;
        w_nextState = S_START;
      end
      S_START: if (w_bitEnd) w_nextState = S_DATA;
`ifdef UART_TX_PARITY_EN
      S_DATA:   if (w_bitEnd && r_bitIdx == 3'd7) w_nextState = S_PARITY;
      S_PARITY: if (w_bitEnd) w_nextState = S_STOP;
`else
      S_DATA:   if (w_bitEnd && r_bitIdx == 3'd7) w_nextState = S_STOP;
`endif
      S_STOP: if (w_bitEnd) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // The bit counter reloads from DIV at every bit boundary, so DIV writes apply to the next bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_bitIdx <= '0;
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_shift  <= r_mem[r_rdPtr];
      r_cnt    <= r_div;
      r_bitIdx <= '0;
      r_parity <= (^r_mem[r_rdPtr]) ^ r_odd;
    end else if (r_state != S_IDLE) begin
      if (w_bitEnd) begin
        r_cnt <= r_div;
        if (r_state == S_DATA) begin
          r_shift  <= {1'b0, r_shift[7:1]};
          r_bitIdx <= r_bitIdx + 3'd1;
        end
      end else begin
        r_cnt <= r_cnt - PSIZE'(1);
      end
    end
  end

  always_comb begin
    txd = 1'b1;
    case (r_state)
      S_START:  txd = 1'b0;
      S_DATA:   txd = r_shift[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd = r_parity;
`endif
      default:  txd = 1'b1;
    endcase
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_rdata;
  assign irq       = r_irqEn & w_empty & ~w_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: expected reads and frames are queued at stimulus
// time and consumed by independent bus and serial monitors.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, irq, txd;

  uart_tx_fifo dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .irq(irq), .txd(txd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycleCount = 0;
  int lastAckCycle = 0;
  int startCycle = 0;
  int framesStarted = 0;
  int framesDone = 0;
  logic gapIrq = 1'b0;
  logic lastStopIrq = 1'b0;

  // Reference model: register image plus the ordered list of bytes still owed on txd.
  logic [15:0] modelDiv = 16'd346;
  logic [2:0]  modelCtrl = 3'd0;
  logic        modelOvf = 1'b0;
  logic [7:0]  expByteQ [$];
  logic [31:0] expRdQ [$];
  string       rdNameQ [$];

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic wbCycle(input logic we, input logic [3:0] off, input logic [31:0] data, input logic [3:0] sel);
    int n;
    @(negedge clk);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = 32'h3005_0000 | {28'h0, off};
    wbs_dat_i = data;
    wbs_sel_i = sel;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wbs_ack_o && n < 20);
    if (!wbs_ack_o) checkOutput("ack timeout", {31'h0, wbs_ack_o}, 32'h1);
    lastAckCycle = cycleCount;
    #1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic regWrite(input logic [3:0] off, input logic [31:0] data, input logic [3:0] sel);
    case (off)
      4'h0: if (sel[0]) begin
        if (expByteQ.size() < DEPTH) expByteQ.push_back(data[7:0]);
        else modelOvf = 1'b1;
      end
      4'h4: if (sel[0] && data[3]) modelOvf = 1'b0;
      4'h8: begin
        if (sel[0]) modelDiv[7:0]  = data[7:0];
        if (sel[1]) modelDiv[15:8] = data[15:8];
      end
      4'hC: if (sel[0]) modelCtrl = data[2:0] & CTRL_MASK;
      default: ;
    endcase
    wbCycle(1'b1, off, data, sel);
  endtask

  // STATUS expectations are only issued while the transmitter is quiescent.
  task automatic regRead(input logic [3:0] off, input string name);
    logic [31:0] e;
    int lvl;
    e = '0;
    case (off)
      4'h4: begin
        lvl = expByteQ.size();
        e[12:8] = lvl[4:0];
        e[3] = modelOvf;
        e[2] = (lvl == 0);
        e[1] = (lvl == DEPTH);
      end
      4'h8: e = {16'h0, modelDiv};
      4'hC: e = {29'h0, modelCtrl};
      default: e = '0;
    endcase
    expRdQ.push_back(e);
    rdNameQ.push_back(name);
    wbCycle(1'b0, off, 32'h0, 4'hF);
  endtask

  task automatic waitFrames(input int target, input string name);
    int n;
    n = 0;
    while (framesDone < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'h0, framesDone >= target}, 32'h1);
  endtask

  task automatic waitStart(input int target, input string name);
    int n;
    n = 0;
    while (framesStarted < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'h0, framesStarted >= target}, 32'h1);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((expByteQ.size() != 0 || framesDone != framesStarted) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'h0, expByteQ.size() == 0 && framesDone == framesStarted}, 32'h1);
    repeat (3) @(negedge clk);
  endtask

  // Random pushes with idle gaps, throttled so the FIFO can never overflow.
  task automatic applyStimulus(input int nOps);
    int n;
    for (int i = 0; i < nOps; i++) begin
      n = 0;
      while (expByteQ.size() >= DEPTH - 1 && n < 5000) begin
        @(negedge clk);
        n++;
      end
      repeat ($urandom_range(0, 20)) @(negedge clk);
      case ($urandom_range(0, 9))
        0: regRead(4'h8, "random DIV read");
        1: regRead(4'hC, "random CTRL read");
        default: regWrite(4'h0, {24'h0, 8'($urandom_range(0, 255))}, 4'h1);
      endcase
    end
  endtask

  initial begin : busMonitor
    logic [31:0] e;
    string nm;
    forever begin
      @(negedge clk);
      if (wbs_ack_o && !wbs_we_i) begin
        if (expRdQ.size() == 0) begin
          checkOutput("unexpected read ack", wbs_dat_o, 32'hDEAD_BEEF);
        end else begin
          e = expRdQ.pop_front();
          nm = rdNameQ.pop_front();
          checkOutput(nm, wbs_dat_o, e);
        end
      end
    end
  end

  // Samples txd every clock of a frame against the ideal waveform for the expected byte.
  initial begin : serialMonitor
    logic [7:0]  eb, got;
    logic [10:0] expBits;
    int nbits, divNow;
    bit ok, aborted, unexpected;
    forever begin
      @(negedge clk);
      if (rst_n && txd === 1'b0) begin
        startCycle = cycleCount;
        framesStarted++;
        divNow = int'(modelDiv);
        unexpected = (expByteQ.size() == 0);
        eb = unexpected ? 8'h00 : expByteQ.pop_front();
`ifdef UART_TX_PARITY_EN
        nbits = 11;
        expBits = {1'b1, (^eb) ^ modelCtrl[2], eb, 1'b0};
`else
        nbits = 10;
        expBits = {1'b0, 1'b1, eb, 1'b0};
`endif
        ok = 1;
        aborted = 0;
        got = '0;
        for (int b = 0; b < nbits && !aborted; b++) begin
          for (int s = 0; s <= divNow && !aborted; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (!rst_n) aborted = 1;
            else begin
              if (txd !== expBits[b]) ok = 0;
              if (b >= 1 && b <= 8 && s == divNow / 2) got[b-1] = txd;
              if (b == nbits - 1 && s == divNow) lastStopIrq = irq;
            end
          end
        end
        if (!aborted) begin
          checks++;
          if (!ok || unexpected) begin
            failures++;
            $display("[TB] FAIL frame: got byte 0x%02h (waveform ok=%0d, unexpected=%0d) expected 0x%02h",
                     got, ok, unexpected, eb);
          end
          @(negedge clk);
          gapIrq = irq;
          checkOutput("idle after stop", {31'h0, txd}, 32'h1);
          framesDone++;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int dataAck, s0, d0;
    repeat (3) @(negedge clk);
    checkOutput("txd in reset", {31'h0, txd}, 32'h1);
    checkOutput("irq in reset", {31'h0, irq}, 32'h0);
    checkOutput("ack in reset", {31'h0, wbs_ack_o}, 32'h0);
    #2 rst_n = 1'b1;
    regRead(4'h0, "reset DATA");
    regRead(4'h4, "reset STATUS");
    regRead(4'h8, "reset DIV");
    regRead(4'hC, "reset CTRL");

    // Single 0xA5 frame at DIV=3.
    regWrite(4'h8, 32'd3, 4'hF);
    regWrite(4'hC, 32'd1, 4'hF);
    d0 = framesDone;
    regWrite(4'h0, 32'hA5, 4'hF);
    dataAck = lastAckCycle;
    waitFrames(d0 + 1, "A5 frame done");
    checkOutput("start-bit latency", startCycle - dataAck, 32'd1);
    checkOutput("irq disabled", {31'h0, irq}, 32'h0);

    // Overflow and drain interrupt.
    regWrite(4'hC, 32'd0, 4'hF);
    for (int i = 0; i < 17; i++) regWrite(4'h0, {24'h0, 8'($urandom_range(0, 255))}, 4'h1);
    regRead(4'h4, "STATUS full+overflow");
    regWrite(4'h4, 32'h8, 4'hF);
    regRead(4'h4, "STATUS overflow cleared");
    d0 = framesDone;
    regWrite(4'hC, 32'd3, 4'hF);
    waitFrames(d0 + 16, "16 frames drained");
    checkOutput("irq low during last stop", {31'h0, lastStopIrq}, 32'h0);
    checkOutput("irq after last stop", {31'h0, gapIrq}, 32'h1);
    regRead(4'h4, "STATUS after drain");
    checkOutput("irq level held", {31'h0, irq}, 32'h1);

    // Byte-lane handling.
    regWrite(4'hC, 32'd0, 4'hF);
    checkOutput("irq masked", {31'h0, irq}, 32'h0);
    regWrite(4'h8, 32'hFFFF_1207, 4'b0001);
    regWrite(4'h8, 32'h0000_0200, 4'b0010);
    regRead(4'h8, "DIV lane writes");
    regWrite(4'h0, 32'h55, 4'b1110);
    regRead(4'h4, "STATUS after unselected push");
    regWrite(4'hC, 32'hFFFF_FFFF, 4'b1110);
    regRead(4'hC, "CTRL unselected lane");
    regWrite(4'hC, 32'h7, 4'b0001);
    regRead(4'hC, "CTRL implemented bits");

    // Randomised traffic at two random bit periods.
    for (int r = 0; r < 2; r++) begin
      regWrite(4'hC, 32'd0, 4'hF);
      regWrite(4'h8, $urandom_range(1, 4), 4'hF);
      regWrite(4'hC, 32'd1, 4'hF);
      applyStimulus(24);
      waitDrain("random drain");
      regRead(4'h4, "STATUS after random drain");
    end

    // Clearing tx_en mid-frame keeps the queued byte.
    regWrite(4'hC, 32'd0, 4'hF);
    regWrite(4'h8, 32'd3, 4'hF);
    regWrite(4'h0, 32'h3C, 4'h1);
    regWrite(4'h0, 32'hC3, 4'h1);
    s0 = framesStarted;
    d0 = framesDone;
    regWrite(4'hC, 32'd1, 4'hF);
    waitStart(s0 + 1, "frame start after enable");
    repeat (15) @(negedge clk);
    regWrite(4'hC, 32'd0, 4'hF);
    waitFrames(d0 + 1, "frame completes after tx_en clear");
    repeat (50) @(negedge clk);
    checkOutput("no frame while disabled", framesStarted, s0 + 1);
    regRead(4'h4, "STATUS level retained");

    // Reset mid-frame flushes the FIFO.
    regWrite(4'h0, 32'h11, 4'h1);
    regWrite(4'h0, 32'h22, 4'h1);
    s0 = framesStarted;
    regWrite(4'hC, 32'd1, 4'hF);
    waitStart(s0 + 1, "frame start before reset");
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("txd on mid-frame reset", {31'h0, txd}, 32'h1);
    expByteQ.delete();
    modelDiv = 16'd346;
    modelCtrl = 3'd0;
    modelOvf = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    regRead(4'h4, "STATUS after reset");
    regRead(4'h8, "DIV after reset");
    regRead(4'hC, "CTRL after reset");
    s0 = framesStarted;
    regWrite(4'hC, 32'd1, 4'hF);
    repeat (60) @(negedge clk);
    checkOutput("FIFO flushed by reset", framesStarted, s0);

`ifdef UART_TX_PARITY_EN
    regWrite(4'h8, 32'd3, 4'hF);
    regWrite(4'hC, 32'd5, 4'hF);
    d0 = framesDone;
    regWrite(4'h0, 32'h07, 4'h1);
    waitFrames(d0 + 1, "odd parity frame");
`endif

    repeat (5) @(negedge clk);
    checkOutput("no pending reads", expRdQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
